spinner_array: RTL and testbench

SPINNER_ARRAY -- requirements
Module: spinner_array

---
 rtl/spinner_pkg.sv | 19 +
 rtl/spinner_chan.sv | 117 +++++++++++
 rtl/spinner_array.sv | 63 ++++++
 tb/tb_spinner_array.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/spinner_pkg.sv
// Shared types and constants for the spinner array: channel mode encoding
// and the headroom used by the signed position arithmetic.
package spinner_pkg;

    typedef enum logic [1:0] {
        MODE_WRAP     = 2'b00,
        MODE_CLAMP    = 2'b01,
        MODE_SPRING   = 2'b10,
        MODE_WRAP_ALT = 2'b11
    } spin_mode_e;

    localparam int INTER_EXTRA = 2;
    localparam int DELTA_W     = 8;

    function automatic int inter_width(input int width);
        return width + INTER_EXTRA;
    endfunction

endpackage

// File: rtl/spinner_chan.sv
// One spinner channel: accelerating button steps on strobe edges, toggle-
// qualified deltas, and wrap / clamp / spring-to-centre position policy.
module spinner_chan
    import spinner_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int STEP_MIN    = 1,
    parameter int STEP_MAX    = 4,
    parameter int ACCEL       = 1,
    parameter int LIMIT_LO    = 0,
    parameter int LIMIT_HI    = 2**WIDTH - 1,
    parameter int CENTER      = 2**(WIDTH - 1),
    parameter int RETURN_STEP = 2,
    parameter int RESET_VAL   = 0
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_strobe_edge,
    input  logic             i_plus,
    input  logic             i_minus,
    input  logic [8:0]       i_spin_in,
    input  logic [1:0]       i_mode,
    output logic [WIDTH-1:0] o_spin_out
);

    localparam int IW = inter_width(WIDTH);
    localparam logic signed [IW-1:0] LO_S  = IW'(LIMIT_LO);
    localparam logic signed [IW-1:0] HI_S  = IW'(LIMIT_HI);
    localparam logic signed [IW-1:0] CTR_S = IW'(CENTER);
    localparam logic signed [IW-1:0] RET_S = IW'(RETURN_STEP);

    logic [WIDTH-1:0]        r_pos;
    logic [WIDTH-1:0]        r_step;
    logic                    r_tog;

    spin_mode_e              w_mode;
    logic                    w_up;
    logic                    w_dn;
    logic                    w_move;
    logic                    w_toggle;
    logic signed [IW-1:0]    w_btn;
    logic signed [IW-1:0]    w_dlt;
    logic signed [IW-1:0]    w_sum;
    logic signed [IW-1:0]    w_clamped;
    logic [WIDTH-1:0]        w_spring;
    logic [WIDTH-1:0]        w_next;
    logic [WIDTH:0]          w_step_inc;
    logic [WIDTH-1:0]        w_step_next;

    assign w_mode   = spin_mode_e'(i_mode);
    assign w_up     = i_strobe_edge & i_plus & ~i_minus;
    assign w_dn     = i_strobe_edge & i_minus & ~i_plus;
    assign w_move   = w_up | w_dn;
    assign w_toggle = i_spin_in[8] ^ r_tog;

    always_comb begin
        w_btn = '0;
        if (w_up)
            w_btn = signed'(IW'(r_step));
        else if (w_dn)
            w_btn = -signed'(IW'(r_step));

        w_dlt = '0;
        if (w_toggle)
            w_dlt = IW'(signed'(i_spin_in[DELTA_W-1:0]));

        w_sum = signed'(IW'(r_pos)) + w_btn + w_dlt;

        w_clamped = w_sum;
        if (w_sum < LO_S)
            w_clamped = LO_S;
        else if (w_sum > HI_S)
            w_clamped = HI_S;

        // Spring return only on frames where the buttons produced no motion.
        w_spring = w_clamped[WIDTH-1:0];
        if (w_mode == MODE_SPRING && i_strobe_edge && !w_move) begin
            if (w_clamped > CTR_S)
                w_spring = (w_clamped - CTR_S > RET_S) ? WIDTH'(w_clamped - RET_S) : WIDTH'(CTR_S);
            else if (w_clamped < CTR_S)
                w_spring = (CTR_S - w_clamped > RET_S) ? WIDTH'(w_clamped + RET_S) : WIDTH'(CTR_S);
        end

        case (w_mode)
            MODE_CLAMP, MODE_SPRING: w_next = w_spring;
            default:                 w_next = w_sum[WIDTH-1:0];
        endcase
    end

    always_comb begin
        w_step_inc  = {1'b0, r_step} + (WIDTH+1)'(ACCEL);
        w_step_next = r_step;
        if (i_strobe_edge) begin
            if (!w_move)
                w_step_next = WIDTH'(STEP_MIN);
            else if (w_step_inc >= (WIDTH+1)'(STEP_MAX))
                w_step_next = WIDTH'(STEP_MAX);
            else
                w_step_next = WIDTH'(w_step_inc);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pos  <= WIDTH'(RESET_VAL);
            r_step <= WIDTH'(STEP_MIN);
            r_tog  <= i_spin_in[8];
        end else begin
            r_pos  <= w_next;
            r_step <= w_step_next;
            r_tog  <= i_spin_in[8];
        end
    end

    assign o_spin_out = r_pos;

endmodule

// File: rtl/spinner_array.sv
// Array of independent spinner channels sharing one frame strobe; the strobe
// rising edge is detected once here and fanned out to every channel.
module spinner_array
    import spinner_pkg::*;
#(
    parameter int CHANNELS    = 2,
    parameter int WIDTH       = 8,
    parameter int STEP_MIN    = 1,
    parameter int STEP_MAX    = 4,
    parameter int ACCEL       = 1,
    parameter int LIMIT_LO    = 0,
    parameter int LIMIT_HI    = 2**WIDTH - 1,
    parameter int CENTER      = 2**(WIDTH - 1),
    parameter int RETURN_STEP = 2,
    parameter int RESET_VAL   = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      strobe,
    input  logic [CHANNELS-1:0]       plus,
    input  logic [CHANNELS-1:0]       minus,
    input  logic [9*CHANNELS-1:0]     spin_in,
    input  logic [2*CHANNELS-1:0]     mode,
    output logic [WIDTH*CHANNELS-1:0] spin_out
);

    logic r_strobe;
    logic w_strobe_edge;

    // Register resets high so a strobe already high at release is not an edge.
    always_ff @(posedge clk) begin
        if (reset)
            r_strobe <= 1'b1;
        else
            r_strobe <= strobe;
    end

    assign w_strobe_edge = strobe & ~r_strobe;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        spinner_chan #(
            .WIDTH       (WIDTH),
            .STEP_MIN    (STEP_MIN),
            .STEP_MAX    (STEP_MAX),
            .ACCEL       (ACCEL),
            .LIMIT_LO    (LIMIT_LO),
            .LIMIT_HI    (LIMIT_HI),
            .CENTER      (CENTER),
            .RETURN_STEP (RETURN_STEP),
            .RESET_VAL   (RESET_VAL)
        ) u_chan (
            .i_clk         (clk),
            .i_reset       (reset),
            .i_strobe_edge (w_strobe_edge),
            .i_plus        (plus[g]),
            .i_minus       (minus[g]),
            .i_spin_in     (spin_in[g*9 +: 9]),
            .i_mode        (mode[g*2 +: 2]),
            .o_spin_out    (spin_out[g*WIDTH +: WIDTH])
        );
    end

endmodule

// File: tb/tb_spinner_array.sv
// Directed scenarios plus a randomized run for spinner_array, each cycle
// checked against an integer reference model of the channel rules.
module tb_spinner_array;

    localparam int CH   = 2;
    localparam int W    = 8;
    localparam int SMIN = 1;
    localparam int SMAX = 4;
    localparam int ACC  = 1;
    localparam int LO   = 0;
    localparam int HI   = 224;
    localparam int CTR  = 100;
    localparam int RET  = 2;
    localparam int RST  = 0;

    logic            clk = 1'b0;
    logic            reset;
    logic            strobe;
    logic [CH-1:0]   plus;
    logic [CH-1:0]   minus;
    logic [9*CH-1:0] spin_in;
    logic [2*CH-1:0] mode;
    logic [W*CH-1:0] spin_out;

    int total = 0;
    int bad   = 0;

    int mdl_pos  [CH];
    int mdl_step [CH];
    int mdl_tog  [CH];
    int mdl_sprev;

    spinner_array #(
        .CHANNELS(CH), .WIDTH(W), .STEP_MIN(SMIN), .STEP_MAX(SMAX), .ACCEL(ACC),
        .LIMIT_LO(LO), .LIMIT_HI(HI), .CENTER(CTR), .RETURN_STEP(RET), .RESET_VAL(RST)
    ) dut (
        .clk(clk), .reset(reset), .strobe(strobe), .plus(plus), .minus(minus),
        .spin_in(spin_in), .mode(mode), .spin_out(spin_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pos_of(input int c);
        return 32'(spin_out[c*W +: W]);
    endfunction

    // Frame-level rules in plain integer arithmetic.
    function automatic void model_update();
        bit edge_seen;
        if (reset) begin
            for (int c = 0; c < CH; c++) begin
                mdl_pos[c]  = RST;
                mdl_step[c] = SMIN;
                mdl_tog[c]  = int'(spin_in[c*9+8]);
            end
            mdl_sprev = 1;
            return;
        end
        edge_seen = strobe && (mdl_sprev == 0);
        mdl_sprev = int'(strobe);
        for (int c = 0; c < CH; c++) begin
            int btn, dlt, v, md;
            bit moved;
            btn = 0; dlt = 0; moved = 0;
            if (edge_seen) begin
                if (plus[c] != minus[c]) begin
                    btn   = plus[c] ? mdl_step[c] : -mdl_step[c];
                    moved = 1;
                    mdl_step[c] = (mdl_step[c] + ACC > SMAX) ? SMAX : mdl_step[c] + ACC;
                end else begin
                    mdl_step[c] = SMIN;
                end
            end
            if (int'(spin_in[c*9+8]) != mdl_tog[c]) begin
                dlt = int'(spin_in[c*9 +: 8]);
                if (dlt > 127) dlt -= 256;
                mdl_tog[c] = int'(spin_in[c*9+8]);
            end
            v  = mdl_pos[c] + btn + dlt;
            md = int'(mode[c*2 +: 2]);
            if (md == 1 || md == 2) begin
                if (v < LO) v = LO;
                if (v > HI) v = HI;
                if (md == 2 && edge_seen && !moved) begin
                    if (v > CTR) v = (v - RET < CTR) ? CTR : v - RET;
                    else if (v < CTR) v = (v + RET > CTR) ? CTR : v + RET;
                end
            end else begin
                v = ((v % 256) + 256) % 256;
            end
            mdl_pos[c] = v;
        end
    endfunction

    task automatic cycle();
        model_update();
        @(posedge clk);
        #1;
        for (int c = 0; c < CH; c++)
            chk($sformatf("model_ch%0d", c), pos_of(c), 32'(mdl_pos[c]));
    endtask

    // Strobe rises for one cycle; the update lands on that first edge.
    task automatic strobe_rise();
        strobe = 1'b1;
        cycle();
    endtask

    task automatic strobe_fall();
        strobe = 1'b0;
        cycle();
    endtask

    task automatic send_delta(input int c, input int d);
        spin_in[c*9 +: 9] = {~spin_in[c*9+8], 8'(d)};
    endtask

    initial begin
        int exp_wrap [5];
        exp_wrap = '{8'hFF, 8'hFD, 8'hFA, 8'hF6, 8'hF2};

        reset = 1'b1; strobe = 1'b0; plus = '0; minus = '0; spin_in = '0; mode = '0;
        cycle(); cycle();
        chk("reset_ch0", pos_of(0), 32'(RST));
        chk("reset_ch1", pos_of(1), 32'(RST));
        reset = 1'b0;
        cycle();

        // Wrap mode decrement with step growth capped at STEP_MAX.
        minus[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            strobe_rise();
            chk($sformatf("wrap_minus_%0d", i), pos_of(0), 32'(exp_wrap[i]));
            strobe_fall();
        end
        minus[0] = 1'b0;
        strobe_rise(); strobe_fall();
        chk("wrap_idle_hold", pos_of(0), 32'hF2);

        // Clamp at LIMIT_HI.
        send_delta(0, -19);
        cycle();
        chk("delta_to_df", pos_of(0), 32'hDF);
        mode[1:0] = 2'b01;
        cycle();
        chk("clamp_enter", pos_of(0), 32'hDF);
        plus[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            strobe_rise();
            chk($sformatf("clamp_plus_%0d", i), pos_of(0), 32'hE0);
            strobe_fall();
        end
        plus[0] = 1'b0;
        strobe_rise(); strobe_fall();

        // Spring toward CENTER.
        mode[1:0] = 2'b10;
        send_delta(0, -124);
        cycle();
        chk("spring_at_center", pos_of(0), 32'd100);
        plus[0] = 1'b1;
        strobe_rise(); chk("spring_plus_0", pos_of(0), 32'd101); strobe_fall();
        strobe_rise(); chk("spring_plus_1", pos_of(0), 32'd103); strobe_fall();
        plus[0] = 1'b0;
        strobe_rise(); chk("spring_ret_0", pos_of(0), 32'd101); strobe_fall();
        strobe_rise(); chk("spring_ret_1", pos_of(0), 32'd100); strobe_fall();
        strobe_rise(); chk("spring_ret_2", pos_of(0), 32'd100); strobe_fall();

        // Button and delta in the same cycle; both buttons reset the step.
        mode[1:0] = 2'b00;
        send_delta(0, -90);
        cycle();
        chk("pos_10", pos_of(0), 32'd10);
        plus[0] = 1'b1;
        send_delta(0, -5);
        strobe_rise(); chk("btn_plus_delta", pos_of(0), 32'd6); strobe_fall();
        minus[0] = 1'b1;
        strobe_rise(); chk("both_no_move", pos_of(0), 32'd6); strobe_fall();
        minus[0] = 1'b0;
        strobe_rise(); chk("step_back_to_1", pos_of(0), 32'd7); strobe_fall();

        // Reset mid-motion with toggle high.
        spin_in[8] = 1'b1;
        strobe = 1'b1;
        reset  = 1'b1;
        cycle();
        chk("reset_mid_motion", pos_of(0), 32'(RST));
        reset = 1'b0; plus = '0; strobe = 1'b0;
        cycle(); cycle();
        chk("no_delta_after_reset", pos_of(0), 32'(RST));
        spin_in[8:0] = {1'b0, 8'd3};
        cycle();
        chk("delta_plus3", pos_of(0), 32'(RST + 3));

        // Long strobe: one update only; channel 0 unaffected by channel 1.
        plus[1] = 1'b1;
        strobe  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycle();
            chk($sformatf("long_strobe_ch1_%0d", i), pos_of(1), 32'(RST + 1));
            chk($sformatf("long_strobe_ch0_%0d", i), pos_of(0), 32'(RST + 3));
        end
        strobe = 1'b0; plus = '0;
        cycle();

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            reset  = ($urandom_range(0, 63) == 0);
            strobe = ($urandom_range(0, 2) == 0) ? ~strobe : strobe;
            plus   = CH'($urandom());
            minus  = CH'($urandom());
            for (int c = 0; c < CH; c++)
                if ($urandom_range(0, 3) == 0)
                    send_delta(c, int'($urandom_range(0, 255)));
            if ($urandom_range(0, 15) == 0)
                mode = (2*CH)'($urandom());
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
